// File: rtl/rv32i_pkg.sv
// Shared RV32I constants used by the memory-stage blocks.
package rv32i_pkg;

  // Data path and address width of the core.
  localparam int DPW = 32;

  // Load/store funct3 encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_store_buffer_if.sv
// Bundle of the MEM-stage store/load request, fence and cache-write signals
// seen by the store buffer. The buffer uses the slave view; the MEM stage and
// cache model use the master view.
interface lsu_store_buffer_if #(
  parameter int DPW = rv32i_pkg::DPW
);

  // Store request from MEM stage
  logic           st_valid;
  logic           st_ready;
  logic [DPW-1:0] st_addr;
  logic [DPW-1:0] st_data;
  logic [2:0]     st_funct3;

  // Load request and forwarding result
  logic           ld_valid;
  logic [DPW-1:0] ld_addr;
  logic [2:0]     ld_funct3;
  logic           ld_hit;
  logic [DPW-1:0] ld_data;
  logic           ld_stall;

  // Status pulses and fence
  logic           misalign_err;
  logic           flush_req;
  logic           flush_done;

  // Cache write port
  logic           mem_we;
  logic [DPW-1:0] mem_addr;
  logic [DPW-1:0] mem_wd;
  logic [3:0]     mem_be;

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3,
    input  ld_valid, ld_addr, ld_funct3,
    input  flush_req,
    output st_ready, ld_hit, ld_data, ld_stall,
    output misalign_err, flush_done,
    output mem_we, mem_addr, mem_wd, mem_be
  );

  modport master (
    output st_valid, st_addr, st_data, st_funct3,
    output ld_valid, ld_addr, ld_funct3,
    output flush_req,
    input  st_ready, ld_hit, ld_data, ld_stall,
    input  misalign_err, flush_done,
    input  mem_we, mem_addr, mem_wd, mem_be
  );

endinterface

// File: rtl/lsu_store_buffer.sv
// Memory-stage store buffer. Stores are converted to lane-aligned word writes
// with byte enables, queued in a circular FIFO and drained one per cycle to
// the data cache when the cache port is free. Younger loads are served from
// the buffer when it holds every byte they need, and stalled when it holds
// only some of them. A fence request drains the buffer completely.
module lsu_store_buffer #(
  parameter int Depth = 4,
  parameter int DPW   = rv32i_pkg::DPW
) (
  input logic               clk,
  input logic               rst_n,
  lsu_store_buffer_if.slave bus
);
  import rv32i_pkg::*;

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam int AW = DPW - 2;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic [AW-1:0]  waddr;
    logic [DPW-1:0] data;
    logic [3:0]     be;
  } entry_t;

  state_e           state_q;
  entry_t           ent_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic             mem_we_q;
  logic [DPW-1:0]   mem_addr_q;
  logic [DPW-1:0]   mem_wd_q;
  logic [3:0]       mem_be_q;
  logic             misalign_err_q;
  logic             flush_done_q;

  logic             full;
  logic             st_ready;
  logic             st_fire;
  logic             do_enq;
  logic             do_drain;

  logic [3:0]       st_be;
  logic [DPW-1:0]   st_lane;
  logic             st_mis;

  logic [3:0]       ld_mask;
  logic             ld_mis;
  logic [PW-1:0]    fwd_idx;
  logic [DPW-1:0]   fwd_data;
  logic [3:0]       fwd_be;
  logic [3:0]       covered;
  logic             ld_chk;
  logic             ld_hit;
  logic             ld_partial;
  logic [DPW-1:0]   ld_shift;
  logic [DPW-1:0]   ld_ext;

  assign full     = (count_q == CW'(Depth));
  assign st_ready = (state_q == S_IDLE) && !full;
  assign st_fire  = bus.st_valid && st_ready;
  assign do_enq   = st_fire && !st_mis;
  // Loads own the cache port in IDLE unless the buffer is full; a fence
  // drains regardless of loads.
  assign do_drain = (count_q != '0) &&
                    ((state_q == S_FLUSH) || !bus.ld_valid || full);
  assign count_d  = count_q + CW'(do_enq) - CW'(do_drain);

  // Store decode: lane position, byte enables and alignment check.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    st_be   = '0;
    st_lane = '0;
    st_mis  = 1'b0;
    case (bus.st_funct3)
      F3_B: begin
        st_be   = 4'b0001 << bus.st_addr[1:0];
        st_lane = DPW'(bus.st_data[7:0]) << {bus.st_addr[1:0], 3'b000};
      end
      F3_H: begin
        st_mis  = bus.st_addr[0];
        st_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        st_lane = DPW'(bus.st_data[15:0]) << {bus.st_addr[1], 4'b0000};
      end
      F3_W: begin
        st_mis  = |bus.st_addr[1:0];
        st_be   = 4'b1111;
        st_lane = bus.st_data;
      end
      default: st_mis = 1'b1;
    endcase
  end

  // Load byte mask and alignment check.
  always_comb begin
    ld_mask = '0;
    ld_mis  = 1'b0;
    case (bus.ld_funct3)
      F3_B, F3_BU: ld_mask = 4'b0001 << bus.ld_addr[1:0];
      F3_H, F3_HU: begin
        ld_mis  = bus.ld_addr[0];
        ld_mask = bus.ld_addr[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        ld_mis  = |bus.ld_addr[1:0];
        ld_mask = 4'b1111;
      end
      default: ld_mis = 1'b1;
    endcase
  end

  // Merge matching entries oldest-first so younger bytes override older ones.
  always_comb begin
    fwd_data = '0;
    fwd_be   = '0;
    fwd_idx  = head_q;
    for (int k = 0; k < Depth; k++) begin
      fwd_idx = head_q + PW'(k);
      if (valid_q[fwd_idx] && (ent_q[fwd_idx].waddr == bus.ld_addr[DPW-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_q[fwd_idx].be[b]) begin
            fwd_data[8*b +: 8] = ent_q[fwd_idx].data[8*b +: 8];
            fwd_be[b]          = 1'b1;
          end
        end
      end
    end
  end

  assign covered    = fwd_be & ld_mask;
  assign ld_chk     = bus.ld_valid && !ld_mis;
  assign ld_hit     = ld_chk && (covered == ld_mask);
  assign ld_partial = ld_chk && (covered != 4'b0000) && (covered != ld_mask);
  assign ld_shift   = fwd_data >> {bus.ld_addr[1:0], 3'b000};

  // Extend the selected bytes according to the load width and signedness.
  always_comb begin
    ld_ext = '0;
    case (bus.ld_funct3)
      F3_B:    ld_ext = {{(DPW-8){ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_ext = {{(DPW-8){1'b0}}, ld_shift[7:0]};
      F3_H:    ld_ext = {{(DPW-16){ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_ext = {{(DPW-16){1'b0}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values, independent of statement order.
      if (do_enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (do_drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Entry payload capture on enqueue.
  // NOTE: the payload array has no reset; valid_q alone says whether an entry
  // holds anything, which keeps the storage a plain register file.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      ent_q[tail_q] <= '{waddr: bus.st_addr[DPW-1:2], data: st_lane, be: st_be};
    end
  end

  // Registered cache write port, presenting the popped entry one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_be_q   <= '0;
    end else begin
      mem_we_q <= do_drain;
      if (do_drain) begin
        mem_addr_q <= {ent_q[head_q].waddr, 2'b00};
        mem_wd_q   <= ent_q[head_q].data;
        mem_be_q   <= ent_q[head_q].be;
      end else begin
        mem_addr_q <= '0;
        mem_wd_q   <= '0;
        mem_be_q   <= '0;
      end
    end
  end

  // Fence FSM with registered flush_done and misalign_err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      flush_done_q   <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      flush_done_q   <= 1'b0;
      misalign_err_q <= st_fire && st_mis;
      case (state_q)
        S_IDLE: begin
          if (bus.flush_req) begin
            if (count_q == '0) begin
              flush_done_q <= 1'b1;
            end else begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Count reaches zero at the last pop; leave one edge later, once
          // that pop's write cycle is over.
          if (count_q == '0) begin
            state_q      <= S_IDLE;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.st_ready     = st_ready;
  assign bus.ld_hit       = ld_hit;
  assign bus.ld_data      = ld_hit ? ld_ext : '0;
  assign bus.ld_stall     = bus.ld_valid &&
                            ((state_q == S_FLUSH) || full || ld_partial);
  assign bus.misalign_err = misalign_err_q;
  assign bus.flush_done   = flush_done_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wd       = mem_wd_q;
  assign bus.mem_be       = mem_be_q;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Scoreboard bench for lsu_store_buffer. Stimulus pushes expected cache
// writes, load results and pulse cycles into queues; a negedge monitor pops
// and compares whenever the DUT presents the matching output.
module tb_lsu_store_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic        stall;
  } ld_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ld_probe = 1'b0;
  int   cyc      = 0;
  int   errors   = 0;
  int   checks   = 0;

  wr_t  wr_q [$];
  ld_t  ld_q [$];
  int   mis_q [$];
  int   fd_q [$];

  wr_t  exp_w;
  ld_t  exp_l;
  int   exp_c;

  lsu_store_buffer_if #(.DPW(32)) bus ();

  lsu_store_buffer #(.Depth(4), .DPW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_q.push_back('{a, d, be});
  endtask

  // One-cycle store request; also ends any probe set up for the same cycle.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    bus.st_valid  = 1'b1;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_funct3 = f3;
    step(1);
    bus.st_valid  = 1'b0;
    ld_probe      = 1'b0;
  endtask

  task automatic set_probe(input logic [31:0] a, input logic [2:0] f3,
                           input logic h, input logic [31:0] d, input logic s);
    bus.ld_addr   = a;
    bus.ld_funct3 = f3;
    ld_q.push_back('{h, d, s});
    ld_probe      = 1'b1;
  endtask

  task automatic probe(input logic [31:0] a, input logic [2:0] f3,
                       input logic h, input logic [31:0] d, input logic s);
    set_probe(a, f3, h, d, s);
    step(1);
    ld_probe = 1'b0;
  endtask

  // Monitor: compare every DUT event against the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) begin
        check("mem_we_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          exp_w = wr_q.pop_front();
          check("mem_addr", bus.mem_addr, exp_w.addr);
          check("mem_wd", bus.mem_wd, exp_w.wd);
          check("mem_be", {28'b0, bus.mem_be}, {28'b0, exp_w.be});
        end
      end
      if (bus.misalign_err) begin
        check("misalign_expected", 32'(mis_q.size() != 0), 32'd1);
        if (mis_q.size() != 0) begin
          exp_c = mis_q.pop_front();
          check("misalign_cycle", 32'(cyc), 32'(exp_c));
        end
      end
      if (bus.flush_done) begin
        check("flush_done_expected", 32'(fd_q.size() != 0), 32'd1);
        if (fd_q.size() != 0) begin
          exp_c = fd_q.pop_front();
          check("flush_done_cycle", 32'(cyc), 32'(exp_c));
        end
      end
      if (ld_probe) begin
        check("ld_probe_expected", 32'(ld_q.size() != 0), 32'd1);
        if (ld_q.size() != 0) begin
          exp_l = ld_q.pop_front();
          check1("ld_hit", bus.ld_hit, exp_l.hit);
          check("ld_data", bus.ld_data, exp_l.data);
          check1("ld_stall", bus.ld_stall, exp_l.stall);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.st_funct3 = 3'b010;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_funct3 = 3'b010;
    bus.flush_req = 1'b0;
    rst_n         = 1'b0;
    step(3);

    // Reset state
    check1("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wd", bus.mem_wd, 32'h0);
    check("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    check1("rst_ld_hit", bus.ld_hit, 1'b0);
    check1("rst_ld_stall", bus.ld_stall, 1'b0);
    check1("rst_misalign", bus.misalign_err, 1'b0);
    check1("rst_flush_done", bus.flush_done, 1'b0);
    rst_n = 1'b1;
    step(1);
    check1("rst_st_ready", bus.st_ready, 1'b1);

    // sw with no loads: enqueue, then drain with one cycle of latency
    exp_wr(32'h10, 32'hDEADBEEF, 4'b1111);
    store(32'h10, 32'hDEADBEEF, 3'b010);
    check1("sw_no_write_at_enqueue", bus.mem_we, 1'b0);
    step(1);
    check1("sw_write_next_cycle", bus.mem_we, 1'b1);
    step(1);
    check1("sw_single_write", bus.mem_we, 1'b0);
    check1("sw_ready_after", bus.st_ready, 1'b1);

    // Loads held: sb is kept and forwarded
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 32'h100;
    bus.ld_funct3 = 3'b010;
    exp_wr(32'h20, 32'h00008000, 4'b0010);
    store(32'h21, 32'h12345680, 3'b000);
    probe(32'h21, 3'b000, 1'b1, 32'hFFFFFF80, 1'b0);
    probe(32'h21, 3'b100, 1'b1, 32'h00000080, 1'b0);
    probe(32'h20, 3'b010, 1'b0, 32'h0, 1'b1);
    probe(32'h100, 3'b010, 1'b0, 32'h0, 1'b0);

    // Two stores to one word merge, younger bytes win
    exp_wr(32'h40, 32'h11223344, 4'b1111);
    store(32'h40, 32'h11223344, 3'b010);
    exp_wr(32'h40, 32'hAABB0000, 4'b1100);
    store(32'h42, 32'h5555AABB, 3'b001);
    probe(32'h40, 3'b010, 1'b1, 32'hAABB3344, 1'b0);
    probe(32'h42, 3'b001, 1'b1, 32'hFFFFAABB, 1'b0);
    probe(32'h40, 3'b101, 1'b1, 32'h00003344, 1'b0);
    bus.ld_valid = 1'b0;
    step(5);
    check1("merge_drained_ready", bus.st_ready, 1'b1);

    // Fill with loads held: same-cycle store invisible, full forces a drain
    bus.ld_valid = 1'b1;
    exp_wr(32'h50, 32'hA0A0A0A0, 4'b1111);
    exp_wr(32'h54, 32'hA1A1A1A1, 4'b1111);
    exp_wr(32'h58, 32'hA2A2A2A2, 4'b1111);
    exp_wr(32'h5C, 32'hA3A3A3A3, 4'b1111);
    set_probe(32'h50, 3'b010, 1'b0, 32'h0, 1'b0);
    store(32'h50, 32'hA0A0A0A0, 3'b010);
    set_probe(32'h50, 3'b010, 1'b1, 32'hA0A0A0A0, 1'b0);
    store(32'h54, 32'hA1A1A1A1, 3'b010);
    store(32'h58, 32'hA2A2A2A2, 3'b010);
    store(32'h5C, 32'hA3A3A3A3, 3'b010);
    check1("full_not_ready", bus.st_ready, 1'b0);
    set_probe(32'h200, 3'b010, 1'b0, 32'h0, 1'b1);
    store(32'h60, 32'hBADBAD00, 3'b010);
    check1("full_write_forced", bus.mem_we, 1'b1);
    check1("ready_after_forced_drain", bus.st_ready, 1'b1);
    probe(32'h200, 3'b010, 1'b0, 32'h0, 1'b0);

    // Misaligned and illegal stores are dropped with a one-cycle pulse
    mis_q.push_back(cyc + 1);
    store(32'h13, 32'h00001234, 3'b001);
    check1("mis_sh_not_enqueued", bus.st_ready, 1'b1);
    step(1);
    mis_q.push_back(cyc + 1);
    store(32'h16, 32'h87654321, 3'b010);
    check1("mis_sw_not_enqueued", bus.st_ready, 1'b1);
    step(1);
    mis_q.push_back(cyc + 1);
    store(32'h30, 32'h0000FFFF, 3'b011);
    check1("mis_f3_not_enqueued", bus.st_ready, 1'b1);
    step(1);

    // Fence with three entries and loads still held
    fd_q.push_back(cyc + 5);
    bus.flush_req = 1'b1;
    step(1);
    bus.flush_req = 1'b0;
    check1("flush_blocks_store", bus.st_ready, 1'b0);
    probe(32'h200, 3'b010, 1'b0, 32'h0, 1'b1);
    check1("flush_write_1", bus.mem_we, 1'b1);
    bus.flush_req = 1'b1;
    step(1);
    bus.flush_req = 1'b0;
    check1("flush_write_2", bus.mem_we, 1'b1);
    step(1);
    check1("flush_write_3", bus.mem_we, 1'b1);
    step(1);
    check1("flush_no_write_4", bus.mem_we, 1'b0);
    step(2);
    check1("flush_back_to_idle", bus.st_ready, 1'b1);

    // Fence on an empty buffer
    fd_q.push_back(cyc + 1);
    bus.flush_req = 1'b1;
    step(1);
    bus.flush_req = 1'b0;
    step(2);

    // Reset in the middle of a fence drain
    exp_wr(32'h70, 32'h00000001, 4'b1111);
    store(32'h70, 32'h00000001, 3'b010);
    store(32'h74, 32'h00000002, 3'b010);
    store(32'h78, 32'h00000003, 3'b010);
    bus.flush_req = 1'b1;
    step(1);
    bus.flush_req = 1'b0;
    step(1);
    check1("midflush_first_write", bus.mem_we, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check1("midrst_mem_we", bus.mem_we, 1'b0);
    check("midrst_mem_addr", bus.mem_addr, 32'h0);
    check("midrst_mem_wd", bus.mem_wd, 32'h0);
    check("midrst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    check1("midrst_ld_hit", bus.ld_hit, 1'b0);
    check("midrst_ld_data", bus.ld_data, 32'h0);
    check1("midrst_ld_stall", bus.ld_stall, 1'b0);
    check1("midrst_flush_done", bus.flush_done, 1'b0);
    check1("midrst_misalign", bus.misalign_err, 1'b0);
    step(2);
    rst_n        = 1'b1;
    bus.ld_valid = 1'b0;
    step(6);
    check1("postrst_no_write", bus.mem_we, 1'b0);
    check1("postrst_ready", bus.st_ready, 1'b1);

    // Every expected event must have been observed
    check("wr_q_left", 32'(wr_q.size()), 32'd0);
    check("ld_q_left", 32'(ld_q.size()), 32'd0);
    check("mis_q_left", 32'(mis_q.size()), 32'd0);
    check("fd_q_left", 32'(fd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
- Memory-stage store buffer between the RV32I MEM pipeline stage and the byte-addressed data cache.
- Queues up to Depth stores (sb/sh/sw) and converts each to a lane-aligned word write with byte enables.
- Drains one store per cycle into the cache whenever the single cache port is free.
- Forwards buffered store data to younger loads (lb/lh/lw/lbu/lhu) and stalls loads that only partially overlap a pending store.

Parameters:
Depth, 4, number of buffer entries (power of two, >=2)
DPW, rv32i_pkg::DPW (32), data/address width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  store request from MEM stage
st_ready  output  1  buffer can accept store this cycle
st_addr  input  DPW  store byte address
st_data  input  DPW  store source data (rs2), low bits used for sb/sh
st_funct3  input  3  000 sb, 001 sh, 010 sw
ld_valid  input  1  load request from MEM stage
ld_addr  input  DPW  load byte address
ld_funct3  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
ld_hit  output  1  ld_data valid from buffer, bypass cache read
ld_data  output  DPW  forwarded, extended load result
ld_stall  output  1  MEM stage must hold the load
misalign_err  output  1  one-cycle pulse, misaligned store dropped
flush_req  input  1  fence: drain all entries
flush_done  output  1  one-cycle pulse, buffer empty after flush
mem_we  output  1  cache write strobe
mem_addr  output  DPW  word-aligned cache address (bits[1:0]=0)
mem_wd  output  DPW  lane-positioned write data
mem_be  output  4  byte enables, bit i = byte lane i

Behaviour:
- Reset (async, rst_n=0): head=tail=count=0, state IDLE, all entries invalid. mem_we, mem_addr, mem_wd, mem_be, ld_hit, ld_data, ld_stall, misalign_err, flush_done all 0. st_ready=1 once rst_n deasserts.
- Reset mid-flush or mid-drain discards all entries; no further mem_we.
- Entry fields: word address (addr[DPW-1:2]), 32-bit lane data, 4-bit be.
  - sb: be = 1<<addr[1:0], data byte at lane addr[1:0].
  - sh: be = 0011 or 1100 by addr[1].
  - sw: be = 1111.
- Enqueue on st_valid && st_ready at the clock edge; tail wraps modulo Depth.
- st_ready = (count<Depth) && state==IDLE.
- No enqueue when full, even if a drain happens the same cycle.
- Misaligned store (sh with addr[0]=1, sw with addr[1:0]!=0, or funct3 not 000/001/010) with st_valid && st_ready: not enqueued; misalign_err=1 the next cycle for exactly one cycle.
- Drain (registered outputs, 1-cycle latency): at an edge where count>0 and a drain condition holds, pop head. mem_we/mem_addr/mem_wd/mem_be present that entry the following cycle; otherwise mem_we=0.
  - IDLE drain condition: !ld_valid || count==Depth. Loads own the cache port unless the buffer is full.
  - Full buffer with ld_valid: drain proceeds and ld_stall=1.
- Enqueue and drain in the same cycle: count unchanged, both pointers advance.
- Forwarding (combinational, same cycle as ld_valid):
  - Load byte mask from ld_funct3/ld_addr[1:0].
  - Merge all valid entries with equal word address in age order; younger bytes override older.
  - Merged be covers the load mask: ld_hit=1, ld_data = selected bytes shifted to bit 0, sign-extended for lb/lh, zero-extended for lbu/lhu/lw.
  - No overlap at all: ld_hit=0, ld_stall=0.
  - Partial overlap: ld_hit=0, ld_stall=1.
  - Store being enqueued in the same cycle is not visible to that load.
  - Entry drained at this edge is still visible during this cycle.
  - Misaligned load: ld_hit=0, no stall (handled elsewhere).
- FSM:
  - IDLE -> FLUSH on flush_req.
  - FLUSH: st_ready=0, ld_stall=1 when ld_valid, drain every cycle regardless of loads.
  - FLUSH -> IDLE when count==0 after the last pop's mem_we cycle; flush_done=1 in that cycle only.
  - flush_req with count==0: flush_done the next cycle.
  - flush_req while in FLUSH is ignored.

Test Plan:
- Reset, then sw 0xDEADBEEF @0x10 with no loads -> next-edge enqueue; following cycle mem_we=1, mem_addr=0x10, mem_wd=0xDEADBEEF, mem_be=1111; count back to 0.
- Hold ld_valid; sb 0x80 @0x21 -> entry kept. Load lb @0x21 -> ld_hit=1, ld_data=0xFFFFFF80. lbu @0x21 -> 0x00000080. Then lw @0x20 -> ld_stall=1, ld_hit=0.
- Two stores to word 0x40 (sw 0x11223344, then sh 0xAABB @0x42), ld_valid held -> lw @0x40 returns 0xAABB3344; after release, drains appear in order with be 1111 then 1100.
- Keep ld_valid=1 and issue 4 stores -> st_ready=0 at count 4; forced drain, ld_stall=1 while full; enqueue attempt when full is not accepted.
- sh @0x13 and sw @0x16 -> each gives misalign_err one-cycle pulse, count unchanged, no mem_we.
- 3 entries queued, flush_req pulse -> st_ready=0, three consecutive mem_we cycles, flush_done one cycle after the third. rst_n low mid-flush -> all outputs 0 immediately, no further writes.
